// File: rtl/sw_debouncer_if.sv
// Switch-conditioning bus: raw pins in, debounced level and edge strobes out.
// Ports: sw_raw (raw asynchronous pins), sw (debounced level),
//        sw_rise / sw_fall (one-cycle per-bit strobes), sw_changed (OR of all strobes).
interface sw_debouncer_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // master: whoever owns the pins and consumes the conditioned result
    modport master (
        output sw_raw,
        input  sw,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // slave: the debouncer itself
    modport slave (
        input  sw_raw,
        output sw,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/sw_debouncer.sv
// Purpose: 2-flop synchronise raw switch pins, then debounce each bit independently.
// Latency: a raw change held steady appears on sw (with one strobe cycle) DEBOUNCE_CYCLES+2 edges later.
// Backpressure: none; free-running, outputs are registered levels/pulses every cycle.
// Ports: clk, reset (sync, active-high), bus (slave modport: sw_raw in; sw, sw_rise, sw_fall, sw_changed out).
module sw_debouncer #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset,
    sw_debouncer_if.slave  bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_e;

    logic [WIDTH-1:0]            sync1_q,  sync1_d;
    logic [WIDTH-1:0]            sync2_q,  sync2_d;
    logic [WIDTH-1:0]            sw_q,     sw_d;
    logic [WIDTH-1:0]            rise_q,   rise_d;
    logic [WIDTH-1:0]            fall_q,   fall_d;
    logic                        changed_q, changed_d;
    state_e [WIDTH-1:0]          state_q,  state_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q,    cnt_d;

    always_comb begin
        sync1_d = bus.sw_raw;
        sync2_d = sync1_q;
        sw_d    = sw_q;
        rise_d  = '0;
        fall_d  = '0;
        state_d = state_q;
        cnt_d   = cnt_q;

        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != sw_q[i]) begin
                        // this edge is the first of the stability window
                        state_d[i] = ST_CHECK;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_CHECK: begin
                    if (sync2_q[i] == sw_q[i]) begin
                        // input fell back before the window completed: drop it silently
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        sw_d[i]    = sync2_q[i];
                        rise_d[i]  = sync2_q[i];
                        fall_d[i]  = ~sync2_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end

        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign bus.sw         = sw_q;
    assign bus.sw_rise    = rise_q;
    assign bus.sw_fall    = fall_q;
    assign bus.sw_changed = changed_q;
endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: directed scenarios followed by random switch activity.
// A reference model pushes the expected registered outputs after every clock edge;
// a monitor pops and compares them on the following falling edge.
module tb_sw_debouncer;
    localparam int W = 3;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] sw;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    obs_t exp_q[$];

    sw_debouncer_if #(.WIDTH(W)) bus_if ();

    sw_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a switch level is accepted once the synchronised input has
    // disagreed with the current debounced level for D consecutive edges since the
    // last acceptance; the synchronised value is the raw pin sampled two edges earlier.
    initial begin : model
        logic [W-1:0] pipe[$];
        logic [W-1:0] s;
        logic [W-1:0] deb;
        int           streak[W];
        obs_t         e;
        deb = '0;
        for (int i = 0; i < W; i++) streak[i] = 0;
        pipe = {3'b000, 3'b000};
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                deb  = '0;
                pipe = {3'b000, 3'b000};
                for (int i = 0; i < W; i++) streak[i] = 0;
            end else begin
                s = pipe.pop_front();
                pipe.push_back(bus_if.sw_raw);
                for (int i = 0; i < W; i++) begin
                    if (s[i] != deb[i]) begin
                        streak[i] = streak[i] + 1;
                        if (streak[i] == D) begin
                            deb[i]    = s[i];
                            e.rise[i] = s[i];
                            e.fall[i] = ~s[i];
                            streak[i] = 0;
                        end
                    end else begin
                        streak[i] = 0;
                    end
                end
            end
            e.sw      = deb;
            e.changed = |(e.rise | e.fall);
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        obs_t got;
        obs_t want;
        @(posedge clk);
        forever begin
            @(negedge clk);
            got = {bus_if.sw, bus_if.sw_rise, bus_if.sw_fall, bus_if.sw_changed};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t got sw=%b rise=%b fall=%b chg=%b, expected an entry",
                         $time, got.sw, got.rise, got.fall, got.changed);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got sw=%b rise=%b fall=%b chg=%b want sw=%b rise=%b fall=%b chg=%b",
                             $time, got.sw, got.rise, got.fall, got.changed,
                             want.sw, want.rise, want.fall, want.changed);
                end
            end
        end
    end

    task automatic step(input logic [W-1:0] raw, input logic rst);
        @(negedge clk);
        bus_if.sw_raw = raw;
        reset         = rst;
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    initial begin : driver
        logic [W-1:0] r;
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus_if.sw_raw = 3'b101;

        // reset for 3 edges with 101 on the pins, then explicit edge-count check
        repeat (3) @(posedge clk);
        step(3'b101, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.sw !== ((k >= 6) ? 3'b101 : 3'b000) ||
                bus_if.sw_rise !== ((k == 6) ? 3'b101 : 3'b000) ||
                bus_if.sw_changed !== (k == 6)) begin
                failures++;
                $display("FAIL reset_release_edge%0d got sw=%b rise=%b chg=%b",
                         k, bus_if.sw, bus_if.sw_rise, bus_if.sw_changed);
            end
        end
        hold(3'b101, 3);
        hold(3'b000, 10);

        // bounce on bit0, then settle high
        for (int k = 0; k < 10; k++) step({2'b00, k[0]}, 1'b0);
        hold(3'b001, 10);
        hold(3'b000, 10);

        // 3-cycle glitch on bit1
        hold(3'b010, 3);
        hold(3'b000, 10);

        // staggered rises on bit0 then bit2
        hold(3'b001, 2);
        hold(3'b101, 10);

        // all high, then simultaneous fall
        hold(3'b111, 10);
        hold(3'b000, 10);

        // reset in the middle of a pending change
        hold(3'b010, 3);
        step(3'b010, 1'b1);
        hold(3'b010, 10);
        hold(3'b000, 10);

        // random pin activity with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            r = W'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                step(r, 1'b1);
            end
            hold(r, $urandom_range(1, 8));
        end

        hold(3'b000, 10);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
